bf_bus_ctrl: RTL and testbench

BF_BUS_CTRL -- requirements
Module: bf_bus_ctrl

---
 rtl/bf_bus_ctrl.sv | 95 +++++++++
 tb/tb_bf_bus_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_bus_ctrl.sv
// bf_bus_ctrl: single-port memory and IO-stream arbiter between an interpreter core and a host.
// Define BF_BUS_STARVE_EN to force a host grant after STARVE_LIMIT cycles of waiting.
module bf_bus_ctrl #(
    parameter int ADDR_WIDTH   = 15,
    parameter int BUS_WIDTH    = 8,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [2:0]            core_op,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [BUS_WIDTH-1:0]  core_wdata,
    output logic [BUS_WIDTH-1:0]  core_rdata,
    input  logic                  core_halted,
    output logic                  core_enable,
    input  logic                  run,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH:0]   host_addr,
    input  logic [BUS_WIDTH-1:0]  host_wdata,
    output logic [BUS_WIDTH-1:0]  host_rdata,
    output logic                  host_ack,
    output logic                  mem_ce,
    output logic                  mem_we,
    output logic [ADDR_WIDTH:0]   mem_addr,
    output logic [BUS_WIDTH-1:0]  mem_wdata,
    input  logic [BUS_WIDTH-1:0]  mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BUS_WIDTH-1:0]  out_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BUS_WIDTH-1:0]  in_data
);
    localparam logic [2:0] READ_PROG  = 3'd1;
    localparam logic [2:0] READ_DATA  = 3'd2;
    localparam logic [2:0] WRITE_DATA = 3'd3;
    localparam logic [2:0] READ_IO    = 3'd4;
    localparam logic [2:0] WRITE_IO   = 3'd5;
    localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);

    logic [BUS_WIDTH-1:0] hold;
    logic                 ack;
    logic                 ack_rd;
    logic                 core_rd;
    logic [3:0]           wait_cnt;
    logic live, is_mem, is_rio, is_wio, eligible, force_grant, host_grant, core_grant, io_stall;

    always_comb begin
        live        = reset_n & run;
        is_mem      = (core_op == READ_PROG) | (core_op == READ_DATA) | (core_op == WRITE_DATA);
        is_rio      = core_op == READ_IO;
        is_wio      = core_op == WRITE_IO;
        // the ack cycle never re-samples host_req, so one request is granted once
        eligible    = reset_n & host_req & ~ack;
        force_grant = eligible & is_mem & (wait_cnt >= LIMIT);
        host_grant  = eligible & (core_halted | ~run | ~is_mem | force_grant);
        io_stall    = (is_wio & ~out_ready) | (is_rio & ~in_valid);
        core_enable = live & ~force_grant & ~io_stall & ~(is_mem & host_grant);
        core_grant  = core_enable & is_mem;
        mem_ce      = core_grant | host_grant;
        mem_we      = core_grant ? core_op == WRITE_DATA : host_grant & host_we;
        mem_addr    = core_grant ? {core_op != READ_PROG, core_addr} : host_addr;
        mem_wdata   = core_grant ? core_wdata : host_wdata;
        out_valid   = live & is_wio;
        out_data    = core_wdata;
        in_ready    = live & is_rio;
        host_ack    = ack;
        host_rdata  = (ack & ack_rd) ? mem_rdata : '0;
        core_rdata  = core_rd ? mem_rdata : hold;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold    <= '0;
            ack     <= 1'b0;
            ack_rd  <= 1'b0;
            core_rd <= 1'b0;
        end else begin
            ack     <= host_grant;
            ack_rd  <= host_grant & ~host_we;
            core_rd <= core_grant & (core_op != WRITE_DATA);
            hold    <= (in_ready & in_valid) ? in_data : core_rd ? mem_rdata : hold;
        end
    end

`ifdef BF_BUS_STARVE_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) wait_cnt <= '0;
        else wait_cnt <= host_grant ? '0 : eligible ? wait_cnt + 4'd1 : wait_cnt;
    end
`else
    assign wait_cnt = '0;
`endif
endmodule

// File: tb/tb_bf_bus_ctrl.sv
// tb_bf_bus_ctrl: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_bf_bus_ctrl;
    localparam int AW = 15;
    localparam int BW = 8;
    localparam int LIMIT = 8;
    localparam logic [2:0] OP_NONE = 3'd0, OP_RPROG = 3'd1, OP_RDATA = 3'd2, OP_WDATA = 3'd3;
    localparam logic [2:0] OP_RIO = 3'd4, OP_WIO = 3'd5;
`ifdef BF_BUS_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic          clock, reset_n;
    logic [2:0]    core_op;
    logic [AW-1:0] core_addr;
    logic [BW-1:0] core_wdata, core_rdata;
    logic          core_halted, core_enable, run;
    logic          host_req, host_we, host_ack;
    logic [AW:0]   host_addr, mem_addr;
    logic [BW-1:0] host_wdata, host_rdata, mem_wdata, mem_rdata, out_data, in_data;
    logic          mem_ce, mem_we, out_valid, out_ready, in_valid, in_ready;

    bf_bus_ctrl #(.ADDR_WIDTH(AW), .BUS_WIDTH(BW), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset_n(reset_n), .core_op(core_op), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_halted(core_halted),
        .core_enable(core_enable), .run(run), .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
        .host_ack(host_ack), .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // synchronous SRAM attached to the DUT, and the reference model's own copy of memory
    logic [BW-1:0] sram    [0:65535];
    logic [BW-1:0] ref_mem [0:65535];
    always @(posedge clock) begin
        if (mem_ce) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else mem_rdata <= sram[mem_addr];
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    bit            m_ack, m_ack_rd, m_fresh, g_ack_now;
    logic [BW-1:0] m_ack_val, m_fresh_val, m_hold;
    int            m_wait;

    task automatic model_reset();
        m_ack = 0;
        m_ack_rd = 0;
        m_fresh = 0;
        m_hold = '0;
        m_wait = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Evaluate one cycle: predict who owns memory and what every output shows, then advance the model.
    task automatic eval();
        bit mem_op, io_w, io_r, eligible, forced, host_go, stall, core_go;
        logic [AW:0] c_addr;
        #1;
        mem_op   = core_op == OP_RPROG || core_op == OP_RDATA || core_op == OP_WDATA;
        io_w     = core_op == OP_WIO;
        io_r     = core_op == OP_RIO;
        c_addr   = {core_op != OP_RPROG, core_addr};
        eligible = host_req && !m_ack;
        forced   = STARVE && eligible && mem_op && m_wait >= LIMIT;
        host_go  = eligible && (core_halted || !run || !mem_op || forced);
        stall    = !run || forced || (io_w && !out_ready) || (io_r && !in_valid) || (mem_op && host_go);
        core_go  = mem_op && !stall;
        check("core_enable", core_enable, !stall);
        check("mem_ce", mem_ce, host_go || core_go);
        if (core_go) begin
            check("mem_addr_core", mem_addr, c_addr);
            check("mem_we_core", mem_we, core_op == OP_WDATA);
            if (core_op == OP_WDATA) check("mem_wdata_core", mem_wdata, core_wdata);
        end else if (host_go) begin
            check("mem_addr_host", mem_addr, host_addr);
            check("mem_we_host", mem_we, host_we);
            if (host_we) check("mem_wdata_host", mem_wdata, host_wdata);
        end
        check("out_valid", out_valid, run && io_w);
        if (io_w) check("out_data", out_data, core_wdata);
        check("in_ready", in_ready, run && io_r);
        check("host_ack", host_ack, m_ack);
        if (m_ack && m_ack_rd) check("host_rdata", host_rdata, m_ack_val);
        check("core_rdata", core_rdata, m_fresh ? m_fresh_val : m_hold);
        g_ack_now = m_ack;
        m_hold    = (run && io_r && in_valid) ? in_data : m_fresh ? m_fresh_val : m_hold;
        m_fresh   = core_go && core_op != OP_WDATA;
        if (m_fresh) m_fresh_val = ref_mem[c_addr];
        m_ack     = host_go;
        m_ack_rd  = host_go && !host_we;
        if (m_ack_rd) m_ack_val = ref_mem[host_addr];
        if (core_go && core_op == OP_WDATA) ref_mem[c_addr] = core_wdata;
        if (host_go && host_we) ref_mem[host_addr] = host_wdata;
        m_wait    = host_go ? 0 : eligible ? m_wait + 1 : m_wait;
    endtask

    task automatic chk_reset();
        check("rst_core_enable", core_enable, 0);
        check("rst_mem_ce", mem_ce, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_host_rdata", host_rdata, 0);
        check("rst_core_rdata", core_rdata, 0);
        check("rst_host_ack", host_ack, 0);
    endtask

    task automatic set_idle();
        run = 1; core_op = OP_NONE; core_addr = '0; core_wdata = '0; core_halted = 0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        out_ready = 0; in_valid = 0; in_data = '0;
    endtask

    initial begin
        int grant_cycle;
        bit seen, h_active;
        for (int i = 0; i < 65536; i++) begin
            logic [BW-1:0] v;
            v = BW'($urandom);
            sram[i] = v;
            ref_mem[i] = v;
        end
        sram[16'h8005] = 8'h2B;
        ref_mem[16'h8005] = 8'h2B;
        set_idle();
        reset_n = 0;
        core_op = OP_WIO; core_halted = 1; host_req = 1;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk_reset();
        tick();
        reset_n = 1;
        set_idle();
        eval();
        // core data read
        tick(); core_op = OP_RDATA; core_addr = 15'h0005; eval();
        check("r18_ce", mem_ce, 1);
        check("r18_addr", mem_addr, 16'h8005);
        tick(); core_op = OP_NONE; eval();
        check("r18_rdata", core_rdata, 8'h2B);
        check("r18_en", core_enable, 1);
        // host write then read while the core is halted
        tick(); core_halted = 1; host_req = 1; host_we = 1; host_addr = 16'h0010; host_wdata = 8'h41; eval();
        check("r19_wgrant", mem_ce && mem_we, 1);
        tick(); eval();
        check("r19_wack", host_ack, 1);
        tick(); host_we = 0; eval();
        check("r19_rgrant", mem_ce && !mem_we, 1);
        tick(); eval();
        check("r19_rack", host_ack, 1);
        check("r19_rdata", host_rdata, 8'h41);
        tick(); host_req = 0; core_halted = 0; eval();
        // print stream with back-pressure
        tick(); core_op = OP_WIO; core_wdata = 8'h48; out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            eval();
            check("r20_stall", core_enable, 0);
            check("r20_data", out_data, 8'h48);
            tick();
        end
        out_ready = 1; eval();
        check("r20_go", core_enable, 1);
        tick(); core_op = OP_NONE; out_ready = 0; eval();
        // read stream arriving late
        tick(); core_op = OP_RIO; in_valid = 0;
        for (int i = 0; i < 2; i++) begin
            eval();
            check("r21_stall", core_enable, 0);
            tick();
        end
        in_valid = 1; in_data = 8'h0A; eval();
        check("r21_go", core_enable, 1);
        tick(); core_op = OP_NONE; in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            eval();
            check("r21_hold", core_rdata, 8'h0A);
            tick();
        end
        // host starved by back-to-back core memory traffic
        core_op = OP_RDATA; core_addr = 15'h0003; host_req = 1; host_we = 0; host_addr = 16'h0123;
        grant_cycle = -1;
        for (int c = 1; c <= 20 && grant_cycle < 0; c++) begin
            eval();
            if (mem_ce && mem_addr == 16'h0123) begin
                grant_cycle = c;
                check("r22_en", core_enable, 0);
            end
            tick();
        end
        check("r22_cycle", grant_cycle, STARVE ? 9 : -1);
        core_op = OP_NONE;
        seen = 0;
        for (int c = 0; c < 4 && !seen; c++) begin
            eval();
            seen = host_ack;
            tick();
        end
        check("r22_ack", seen, 1);
        host_req = 0; eval();
        // reset during a host read grant
        tick(); core_halted = 1; host_req = 1; host_we = 0; host_addr = 16'h0042; eval();
        check("r23_grant", mem_ce, 1);
        #1 reset_n = 0;
        #1 chk_reset();
        host_req = 0;
        model_reset();
        tick(); tick();
        reset_n = 1; core_halted = 0;
        for (int i = 0; i < 3; i++) begin
            eval();
            check("r23_noack", host_ack, 0);
            tick();
        end
        // randomized traffic
        h_active = 0;
        for (int n = 0; n < 3000; n++) begin
            run = $urandom_range(0, 9) != 0;
            core_halted = $urandom_range(0, 9) == 0;
            core_op = 3'($urandom_range(0, 5));
            core_addr = 15'($urandom_range(0, 7));
            core_wdata = BW'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            in_data = BW'($urandom);
            if (!h_active && $urandom_range(0, 3) == 0) begin
                h_active = 1;
                host_we = 1'($urandom_range(0, 1));
                host_addr = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 7))};
                host_wdata = BW'($urandom);
            end
            host_req = h_active;
            eval();
            if (g_ack_now) h_active = 0;
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
